// File: rtl/mc_alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding and controller states.
// Also holds a small helper that picks out the iterative opcodes.
package mc_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_ADD  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIVU = 3'd4,
    OP_REMU = 3'd5,
    OP_SUB  = 3'd6,
    OP_SLTU = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_e;

  function automatic logic is_div_op(input op_e op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mc_alu_div.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// The first bit is resolved on the start edge, so done rises WIDTH-1 edges later.
module mc_alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the difference only when it does not borrow.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dsr
  );
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {rem, quo[WIDTH-1]};
    diff = sh - {1'b0, dsr};
    if (diff[WIDTH])
      return {sh[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    else
      return {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
  endfunction

  logic [2*WIDTH-1:0] first_step;
  logic [2*WIDTH-1:0] next_step;

  assign first_step = div_step('0, dividend, divisor);
  assign next_step  = div_step(rem_reg, quo_reg, dsr_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dsr_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      rem_reg  <= first_step[2*WIDTH-1:WIDTH];
      quo_reg  <= first_step[WIDTH-1:0];
      dsr_reg  <= divisor;
      cnt_reg  <= CW'(WIDTH - 1);
      busy_reg <= 1'b1;
    end else if (busy_reg && (cnt_reg != '0)) begin
      rem_reg <= next_step[2*WIDTH-1:WIDTH];
      quo_reg <= next_step[WIDTH-1:0];
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done      = busy_reg && (cnt_reg == '0);
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

endmodule

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus an iterative unsigned
// divider, behind a valid/ready request port and a registered result port.
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIV_LAT = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_zero
);

  localparam int CW = $clog2(DIV_LAT + 1);

  state_e           state_reg;
  logic [CW-1:0]    iter_cnt_reg;
  op_e              div_op_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             div_zero_reg;

  op_e              op;
  logic             accept;
  logic             b_is_zero;
  logic             div_start;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] div_res;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  assign op        = op_e'(ctrl);
  assign in_ready  = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign b_is_zero = (src_b == '0);
  assign div_start = accept && is_div_op(op) && !b_is_zero;

  // Single-cycle datapath; divide-by-zero answers are produced here too.
  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_ADD:  alu_res = src_a + src_b;
      OP_MUL:  alu_res = src_a * src_b;
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = src_a;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      default: alu_res = '0;
    endcase
  end

  mc_alu_div #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (src_a),
    .divisor  (src_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign div_res = (div_op_reg == OP_DIVU) ? div_quo : div_rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      iter_cnt_reg  <= '0;
      div_op_reg    <= OP_AND;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      div_zero_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (div_start) begin
              // Any previous result was consumed on this edge (in_ready).
              state_reg     <= ST_DIV;
              iter_cnt_reg  <= CW'(DIV_LAT - 1);
              div_op_reg    <= op;
              out_valid_reg <= 1'b0;
            end else begin
              result_reg    <= alu_res;
              zero_reg      <= (alu_res == '0);
              div_zero_reg  <= is_div_op(op) && b_is_zero;
              out_valid_reg <= 1'b1;
            end
          end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        ST_DIV: begin
          if (iter_cnt_reg != '0) begin
            iter_cnt_reg <= iter_cnt_reg - 1'b1;
          end else if (div_done) begin
            result_reg    <= div_res;
            zero_reg      <= (div_res == '0);
            div_zero_reg  <= 1'b0;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_mc_alu.sv
// Scoreboard bench for mc_alu: driver pushes reference answers on acceptance,
// an independent monitor pops and compares whenever a result is consumed.
module tb_mc_alu;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    bit           z;
    bit           dz;
    int           exp_cyc;
    int           op;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   ctrl;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         div_zero;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   seen_head = 0;
  bit   rand_ready = 0;

  mc_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ctrl     (ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .div_zero (div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference behaviour straight from the operation definitions.
  function automatic exp_t model(int op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint unsigned r;
    case (op)
      0: r = ua & ub;
      1: r = ua | ub;
      2: r = (ua + ub) % (64'd1 << W);
      3: r = (ua * ub) % (64'd1 << W);
      4: r = (ub == 0) ? (64'd1 << W) - 1 : ua / ub;
      5: r = (ub == 0) ? ua : ua % ub;
      6: r = (ua + (64'd1 << W) - ub) % (64'd1 << W);
      default: r = (ua < ub) ? 1 : 0;
    endcase
    e.res = r[W-1:0];
    e.z   = (r == 0);
    e.dz  = (op == 4 || op == 5) && (ub == 0);
    e.op  = op;
    e.exp_cyc = cyc + (((op == 4 || op == 5) && ub != 0) ? W + 1 : 1);
    return e;
  endfunction

  // Present a request until accepted; the reference answer is queued at
  // the moment acceptance is certain (in_ready seen high before the edge).
  task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = 3'(op);
    src_a = a;
    src_b = b;
    #1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 64'(n), 64'd0);
    end else begin
      sb.push_back(model(op, a, b));
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency check on first appearance, data check on consume.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(out_valid), 64'd0);
        end else begin
          e = sb[0];
          if (!seen_head) begin
            seen_head = 1;
            chk($sformatf("latency_op%0d", e.op), 64'(cyc), 64'(e.exp_cyc));
          end
          if (out_ready) begin
            chk($sformatf("result_op%0d", e.op), 64'(result), 64'(e.res));
            chk($sformatf("zero_op%0d", e.op), 64'(zero), 64'(e.z));
            chk($sformatf("div_zero_op%0d", e.op), 64'(div_zero), 64'(e.dz));
            $display("txn op=%0d result=%h zero=%0d div_zero=%0d", e.op, result, zero, div_zero);
            void'(sb.pop_front());
            seen_head = 0;
          end
        end
      end
    end
  end

  initial begin
    int bad;
    int op;
    logic [W-1:0] a, b;

    reset = 1'b1;
    in_valid = 1'b0;
    ctrl = '0;
    src_a = '0;
    src_b = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_flags", 64'({zero, div_zero}), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("ready_after_reset", 64'(in_ready), 64'd1);

    // Directed corner cases.
    issue(2, 32'hFFFF_FFFF, 32'd1);
    issue(4, 32'd100, 32'd7);
    bad = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      #1;
      if (in_ready) bad++;
    end
    chk("in_ready_during_div", 64'(bad), 64'd0);
    issue(5, 32'd100, 32'd7);
    issue(4, 32'd5, 32'd0);
    issue(5, 32'd5, 32'd0);
    drain();

    // Output back-pressure on a SUB result.
    out_ready = 1'b0;
    issue(6, 32'd3, 32'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      ctrl = 3'd2;
      src_a = 32'd20;
      src_b = 32'd22;
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_result", 64'(result), 64'hFFFF_FFFE);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    if (in_ready) sb.push_back(model(2, 32'd20, 32'd22));
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Back-to-back single-cycle ops.
    issue(3, 32'h0001_0000, 32'h0001_0000);
    issue(7, 32'd2, 32'd3);
    drain();

    // Reset in the middle of a divide.
    issue(4, 32'hDEAD_BEEF, 32'd13);
    repeat (9) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_div_reset_valid", 64'(out_valid), 64'd0);
    chk("mid_div_reset_result", 64'(result), 64'd0);
    sb.delete();
    seen_head = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_mid_reset", 64'(in_ready), 64'd1);
    repeat (40) @(negedge clk);
    issue(2, 32'd40, 32'd2);
    drain();

    // Randomised traffic with random output back-pressure.
    rand_ready = 1;
    for (int i = 0; i < 120; i++) begin
      op = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        2: a = b;
        default: ;
      endcase
      issue(op, a, b);
    end
    drain();
    rand_ready = 0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
